// File: rtl/burst_sequencer.sv
// Sequences BURSTS pulse trains through the downstream pulse generator,
// spacing them by GAP idle cycles and watching each train for a done-timeout.
module burst_sequencer #(
  parameter int BURSTS  = 8,
  parameter int GAP     = 16,
  parameter int RUN_LEN = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       pg_done,
  output logic       pg_run,
  output logic       pg_reset,
  output logic       busy,
  output logic [7:0] burst_idx,
  output logic       finished,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_ARM, S_WAIT_DONE, S_GAP, S_FIN, S_ABORT
  } state_t;

  typedef struct packed {
    logic pg_run;
    logic pg_reset;
    logic busy;
    logic finished;
  } outs_t;

  localparam logic [15:0] RUN_LAST = 16'(RUN_LEN - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [7:0]  BURSTS_N = 8'(BURSTS);

  // Outputs are decoded from the state being entered, so they stay registered
  // and line up with the state cycle by cycle.
  function automatic outs_t decode(input state_t s);
    outs_t o;
    o.pg_run   = (s == S_ARM);
    o.pg_reset = (s == S_INIT) || (s == S_ABORT);
    o.busy     = (s != S_IDLE);
    o.finished = (s == S_FIN);
    return o;
  endfunction

  state_t      state;
  outs_t       outs;
  logic [15:0] cnt;

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // the reset is synchronous and only appears under the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      outs      <= '0;
      cnt       <= '0;
      burst_idx <= '0;
      error     <= 1'b0;
    end else if (abort && state != S_IDLE && state != S_ABORT) begin
      // Abort outranks done and timeout: no index bump, no error.
      state <= S_ABORT;
      outs  <= decode(S_ABORT);
      cnt   <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          state     <= S_INIT;
          outs      <= decode(S_INIT);
          burst_idx <= '0;
          error     <= 1'b0;
        end
        S_INIT: begin
          state <= S_ARM;
          outs  <= decode(S_ARM);
          cnt   <= '0;
        end
        S_ARM: if (cnt == RUN_LAST) begin
          state <= S_WAIT_DONE;
          outs  <= decode(S_WAIT_DONE);
          cnt   <= '0;
        end else begin
          cnt <= cnt + 16'd1;
        end
        S_WAIT_DONE: if (pg_done) begin
          burst_idx <= burst_idx + 8'd1;
          cnt       <= '0;
          if (burst_idx + 8'd1 == BURSTS_N) begin
            state <= S_FIN;
            outs  <= decode(S_FIN);
          end else begin
            state <= S_GAP;
            outs  <= decode(S_GAP);
          end
        end else if (cnt == TO_LAST) begin
          error <= 1'b1;
          state <= S_ABORT;
          outs  <= decode(S_ABORT);
          cnt   <= '0;
        end else begin
          cnt <= cnt + 16'd1;
        end
        S_GAP: if (cnt == GAP_LAST) begin
          state <= S_ARM;
          outs  <= decode(S_ARM);
          cnt   <= '0;
        end else begin
          cnt <= cnt + 16'd1;
        end
        S_FIN, S_ABORT: begin
          state <= S_IDLE;
          outs  <= decode(S_IDLE);
        end
        default: begin
          state <= S_IDLE;
          outs  <= decode(S_IDLE);
        end
      endcase
    end
  end

  assign pg_run   = outs.pg_run;
  assign pg_reset = outs.pg_reset;
  assign busy     = outs.busy;
  assign finished = outs.finished;

endmodule

// File: doc/burst_sequencer.md
# burst_sequencer

Control stage directly upstream of the gated-clock pulse generator (`pulsegate`). It drives that stage's `reset` and `run` inputs and monitors its `done` output. One `start` request produces `BURSTS` pulse trains separated by `GAP` idle cycles. The block reports progress, completion, and a done-timeout error to the counter's host logic. Everything runs on the same `clk` that the pulse generator gates.

## Interface
- `BURSTS`, default 8: number of pulse trains per request; legal range 1..255.
- `GAP`, default 16: idle `clk` cycles between consecutive trains; legal range 1..65535.
- `RUN_LEN`, default 2: cycles `pg_run` is held high to arm each train; legal range 1..255.
- `TIMEOUT`, default 1024: maximum WAIT_DONE cycles before declaring an error; legal range 2..65535.
- `clk`, in, 1: system clock; also the clock being gated downstream. Clock `clk`.
- `reset`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: request a sequence; sampled only in IDLE.
- `abort`, in, 1: cancel the sequence in progress.
- `pg_done`, in, 1: `done` from the pulse generator.
- `pg_run`, out, 1: drives the pulse generator's `run`.
- `pg_reset`, out, 1: drives the pulse generator's `reset`.
- `busy`, out, 1: high whenever the state is not IDLE.
- `burst_idx`, out, 8: count of trains completed in the current sequence.
- `finished`, out, 1: one-cycle pulse when all `BURSTS` trains are complete.
- `error`, out, 1: sticky timeout flag.

## Operation
- States: IDLE, INIT, ARM, WAIT_DONE, GAP, FIN, ABORT.
- All outputs are registered and decoded from the state:
  - `pg_reset` = INIT or ABORT.
  - `pg_run` = ARM.
  - `finished` = FIN.
  - `busy` = not IDLE.
- Reset values: state IDLE; all outputs 0; `burst_idx` = 0; all internal counters 0.
- IDLE: on `start`=1, go to INIT, clear `burst_idx`, and clear `error`.
- INIT: 1 cycle, then ARM.
- ARM: `RUN_LEN` cycles, then WAIT_DONE with the timeout counter cleared.
- WAIT_DONE: `pg_run`=0; increment the timeout counter each cycle.
  - If `pg_done`=1: increment `burst_idx`. Go to FIN if the new value equals `BURSTS`, otherwise go to GAP.
  - If `pg_done`=0 and the counter reaches `TIMEOUT`-1: set `error`=1 and go to ABORT.
- GAP: `GAP` cycles, then ARM. The pulse generator is not reset between trains.
- FIN: 1 cycle, then IDLE.
- ABORT: 1 cycle, then IDLE. `finished` is not pulsed.
- `abort`=1 in any state except IDLE and ABORT: go to ABORT next cycle. `burst_idx` holds its value; `error` is unchanged.
- Simultaneous events:
  - `abort` with a timeout in the same cycle: abort wins and `error` is not set.
  - `abort` with `pg_done` in WAIT_DONE: abort wins and `burst_idx` is not incremented.
  - `abort` with `start` in IDLE: start wins, because `abort` is ignored in IDLE.
- `start` outside IDLE is ignored and not queued.
- `reset` mid-sequence: immediate return to the reset values. The pulse generator is reset separately by the system `reset`.

## Timing
- `start` sampled at edge 0 gives:
  - INIT in cycle 1;
  - ARM in cycles 2..1+`RUN_LEN`;
  - WAIT_DONE from cycle 2+`RUN_LEN`.
- Pulse generator behaviour (COUNT = its parameter):
  - It clears `done` on the first edge that samples `pg_run`=1, so `pg_done` is 0 in the first WAIT_DONE cycle for any `RUN_LEN` ≥ 1.
  - It raises `done` after COUNT edges with `run` low, so `pg_done` is first seen in WAIT_DONE cycle COUNT+1. WAIT_DONE therefore lasts COUNT+1 cycles.
- `TIMEOUT` must exceed COUNT+1.
- `burst_idx` updates in the cycle after the WAIT_DONE exit.
- `finished` and the final `burst_idx` value are visible together. `busy` falls the cycle after `finished`.
- Sequence length in cycles: 1 + `BURSTS`·(`RUN_LEN`+COUNT+1) + (`BURSTS`−1)·`GAP` + 1.

## Test plan
All scenarios use a pulse generator with COUNT=4.
- **Nominal sequence.** `BURSTS`=3, `GAP`=5, `RUN_LEN`=2, `start` at edge 0.
  - INIT in cycle 1.
  - ARM in cycles 2-3, 14-15 and 26-27.
  - WAIT_DONE in cycles 4-8, 16-20 and 28-32.
  - `finished` in cycle 33; `busy` low in cycle 34; `burst_idx`=3.
  - 12 full gated clock pulses in total.
- **Minimum settings.** `BURSTS`=1, `RUN_LEN`=1.
  - `pg_run` high for exactly 1 cycle.
  - `finished` in cycle 8.
  - `pg_done` never sampled high before the train completes.
- **Timeout.** `pg_done` tied to 0, `TIMEOUT`=10.
  - `error`=1 and `pg_reset`=1 exactly 10 cycles after WAIT_DONE entry; `finished` never asserts.
  - A subsequent `start` clears `error`.
- **Abort.** `abort` pulse in the second GAP of a 3-burst run.
  - `pg_reset` high for 1 cycle; `burst_idx`=2; no `finished`; `error`=0.
- **Simultaneous events.**
  - `abort` in the same cycle `pg_done` is first seen: `burst_idx` is not incremented and the next state is ABORT.
  - `start` pulses while `busy`: ignored, and the cycle count is unchanged.
- **Reset mid-sequence.** `reset` in ARM.
  - The next cycle has all outputs 0 and the state IDLE.
  - A fresh `start` reproduces the nominal timing.
